// File: rtl/aes_cipher_iter_pkg.sv
// rtl/aes_cipher_iter_pkg.sv - shared AES field helpers, S-box and FSM encodings
package aes_cipher_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse is a^254 (square-and-multiply over a^2..a^128), which also maps 0 to 0.
  function automatic logic [7:0] subbytef(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] inv;
    p   = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_cipher_iter_if.sv
// rtl/aes_cipher_iter_if.sv - key schedule, plaintext and ciphertext handshake bundle
interface aes_cipher_iter_if #(
  parameter int NB = 4,
  parameter int NR = 10
);
  logic [32*NB*(NR+1)-1:0] w;
  logic [127:0]            in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [127:0]            out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;

  modport master (
    output w, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  w, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy
  );
endinterface

// File: rtl/aes_cipher_iter_round.sv
// rtl/aes_cipher_iter_round.sv - one combinational AES round (SubBytes, ShiftRows, MixColumns, AddRoundKey)
module aes_cipher_iter_round
  import aes_cipher_iter_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] next_state
);

  // Byte k sits at [127-8k -: 8]; column c holds bytes 4c..4c+3, row r is k%4.
  function automatic logic [127:0] shiftrows(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return t;
  endfunction

  function automatic logic [127:0] mixcolumns(input logic [127:0] s);
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      t[127-32*c -: 8] = gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3;
      t[119-32*c -: 8] = a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3;
      t[111-32*c -: 8] = a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3);
      t[103-32*c -: 8] = gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3);
    end
    return t;
  endfunction

  logic [127:0] sub_bytes;
  logic [127:0] shifted;

  always_comb begin
    sub_bytes = '0;
    for (int i = 0; i < 16; i++) begin
      sub_bytes[127-8*i -: 8] = subbytef(state[127-8*i -: 8]);
    end
    shifted    = shiftrows(sub_bytes);
    next_state = (last ? shifted : mixcolumns(shifted)) ^ rk;
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// rtl/aes_cipher_iter.sv - iterative AES encryption core, one round per clock
module aes_cipher_iter
  import aes_cipher_iter_pkg::*;
#(
  parameter int NK = 4,
  parameter int NB = 4,
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst,
  aes_cipher_iter_if.slave bus
);

  localparam int            RW       = $clog2(NR + 1);
  localparam logic [RW-1:0] RND_LAST = RW'(NR);
  // A key length / round count mismatch leaves the core permanently not ready.
  localparam bit            CFG_OK   = (NR == NK + 6) && (NB == 4);

  state_e          state_q, state_d;
  logic [RW-1:0]   rnd_q, rnd_d;
  logic [127:0]    data_q, data_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [127:0]    rk_tbl [NR+1];
  logic [127:0]    rk;
  logic [127:0]    round_out;

  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign rk_tbl[r] = {bus.w[128*r +: 32], bus.w[128*r+32 +: 32],
                        bus.w[128*r+64 +: 32], bus.w[128*r+96 +: 32]};
  end

  assign rk = rk_tbl[(state_q == ST_RUN) ? rnd_q : '0];

  aes_cipher_iter_round u_round (
    .state      (data_q),
    .rk         (rk),
    .last       (rnd_q == RND_LAST),
    .next_state (round_out)
  );

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && CFG_OK) begin
          data_d  = bus.in_data ^ rk;
          rnd_d   = RW'(1);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        data_d = round_out;
        if (rnd_q == RND_LAST) begin
          state_d = ST_DONE;
        end else begin
          rnd_d = rnd_q + RW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
          rnd_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rnd_d   = '0;
        data_d  = '0;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rnd_q       <= '0;
      data_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      data_q      <= data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q & ~rst & CFG_OK;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb/tb_aes_cipher_iter.sv - self-checking bench for aes_cipher_iter (AES-128 and AES-256 instances)
module tb_aes_cipher_iter;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  logic [7:0] sb [256];

  always #5 clk = ~clk;

  aes_cipher_iter_if #(.NB(4), .NR(10)) b4 ();
  aes_cipher_iter_if #(.NB(4), .NR(14)) b8 ();

  aes_cipher_iter #(.NK(4), .NB(4), .NR(10)) u4 (.clk(clk), .rst(rst), .bus(b4));
  aes_cipher_iter #(.NK(8), .NB(4), .NR(14)) u8 (.clk(clk), .rst(rst), .bus(b8));

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] c = 8'h63;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] m_subword(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [1919:0] m_expand(input logic [255:0] key, input int nk);
    logic [31:0]   wd [60];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1919:0] res = '0;
    int            nw = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = wd[i-1];
      if (i % nk == 0) begin
        t = m_subword({t[23:0], t[31:24]});
        t[31:24] = t[31:24] ^ rc;
        rc = m_mul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = m_subword(t);
      end
      wd[i] = wd[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) res[32*i +: 32] = wd[i];
    return res;
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] pt, input logic [1919:0] w, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int rd = 0; rd <= nr; rd++) begin
      if (rd > 0) begin
        for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
        if (rd != nr) begin
          for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
            for (int r = 0; r < 4; r++)
              s[4*c+r] = m_mul(a[r], 8'h02) ^ m_mul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
          end
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[32*(4*rd+c) + 24 - 8*r +: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- bus access ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_w(input int sel, input logic [1919:0] wf);
    if (sel == 0) b4.w = wf[1407:0];
    else          b8.w = wf;
  endtask

  task automatic drv(input int sel, input logic [127:0] d, input logic v, input logic ordy);
    if (sel == 0) begin b4.in_data = d; b4.in_valid = v; b4.out_ready = ordy; end
    else          begin b8.in_data = d; b8.in_valid = v; b8.out_ready = ordy; end
  endtask

  function automatic logic o_valid(input int sel);  return (sel == 0) ? b4.out_valid : b8.out_valid; endfunction
  function automatic logic i_ready(input int sel);  return (sel == 0) ? b4.in_ready  : b8.in_ready;  endfunction
  function automatic logic o_busy(input int sel);   return (sel == 0) ? b4.busy      : b8.busy;      endfunction
  function automatic logic [127:0] o_data(input int sel); return (sel == 0) ? b4.out_data : b8.out_data; endfunction

  // One full block: accept, measure latency, compare ciphertext, complete handshake.
  task automatic run_block(input int sel, input logic [255:0] key, input logic [127:0] pt,
                           input logic [127:0] kat, input bit has_kat, input string tag);
    int nr = (sel == 0) ? 10 : 14;
    int nk = (sel == 0) ? 4 : 8;
    int n = 0;
    int lat = 0;
    logic [1919:0] wf = m_expand(key, nk);
    logic [127:0]  exp_ct = m_encrypt(pt, wf, nr);
    set_w(sel, wf);
    drv(sel, pt, 1'b1, 1'b0);
    while (!i_ready(sel) && n < 20) begin tick(); n++; end
    total_cnt++;
    if (i_ready(sel) !== 1'b1) $display("FAIL %s in_ready: got %b expected 1", tag, i_ready(sel));
    else pass_cnt++;
    tick();
    drv(sel, pt, 1'b0, 1'b0);
    total_cnt++;
    if (o_busy(sel) !== 1'b1) $display("FAIL %s busy_after_accept: got %b expected 1", tag, o_busy(sel));
    else pass_cnt++;
    while (o_valid(sel) !== 1'b1 && lat < 40) begin tick(); lat++; end
    total_cnt++;
    if (lat !== nr) $display("FAIL %s latency: got %0d edges expected %0d", tag, lat, nr);
    else pass_cnt++;
    total_cnt++;
    if (o_data(sel) !== exp_ct) $display("FAIL %s model_ct: got %h expected %h", tag, o_data(sel), exp_ct);
    else pass_cnt++;
    if (has_kat) begin
      total_cnt++;
      if (o_data(sel) !== kat) $display("FAIL %s kat_ct: got %h expected %h", tag, o_data(sel), kat);
      else pass_cnt++;
    end
    drv(sel, pt, 1'b0, 1'b1);
    tick();
    drv(sel, pt, 1'b0, 1'b0);
    total_cnt++;
    if (o_valid(sel) !== 1'b0 || i_ready(sel) !== 1'b1)
      $display("FAIL %s after_handshake: got valid=%b ready=%b expected valid=0 ready=1",
               tag, o_valid(sel), i_ready(sel));
    else pass_cnt++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drv(0, 128'h1, 1'b1, 1'b0);
    drv(1, 128'h1, 1'b1, 1'b0);
    b4.w = '0;
    b8.w = '0;
    repeat (3) tick();
    total_cnt++;
    if (b4.in_ready !== 1'b0 || b8.in_ready !== 1'b0)
      $display("FAIL reset_in_ready: got %b/%b expected 0/0", b4.in_ready, b8.in_ready);
    else pass_cnt++;
    total_cnt++;
    if (b4.out_valid !== 1'b0 || b8.out_valid !== 1'b0 || b4.busy !== 1'b0 || b8.busy !== 1'b0)
      $display("FAIL reset_flags: got valid=%b/%b busy=%b/%b expected all 0",
               b4.out_valid, b8.out_valid, b4.busy, b8.busy);
    else pass_cnt++;
    total_cnt++;
    if (b4.out_data !== 128'h0 || b8.out_data !== 128'h0)
      $display("FAIL reset_out_data: got %h/%h expected 0", b4.out_data, b8.out_data);
    else pass_cnt++;
    rst = 1'b0;
    drv(0, 128'h1, 1'b0, 1'b0);
    drv(1, 128'h1, 1'b0, 1'b0);
    tick();
    total_cnt++;
    if (b4.in_ready !== 1'b1 || b4.busy !== 1'b0 || b8.busy !== 1'b0)
      $display("FAIL reset_release: got ready=%b busy=%b/%b expected ready=1 busy=0/0",
               b4.in_ready, b4.busy, b8.busy);
    else pass_cnt++;
  endtask

  task automatic test_fips();
    run_block(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32, 1'b1, "fips_b");
    run_block(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, "fips_c1");
    run_block(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              128'h00112233445566778899aabbccddeeff,
              128'h8ea2b7ca516745bfeafc49904b496089, 1'b1, "fips_c3");
  endtask

  task automatic test_random();
    logic [255:0] key;
    logic [127:0] pt;
    for (int i = 0; i < 4; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      run_block(i % 2, key, pt, 128'h0, 1'b0, (i % 2 == 0) ? "rand_nk4" : "rand_nk8");
    end
  endtask

  task automatic test_back_pressure();
    logic [255:0]  key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    logic [127:0]  pa = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0]  pb = {$urandom, $urandom, $urandom, $urandom};
    logic [1919:0] wf = m_expand(key, 4);
    logic [127:0]  ea = m_encrypt(pa, wf, 10);
    logic [127:0]  eb = m_encrypt(pb, wf, 10);
    int lat = 0;
    int bad = 0;
    set_w(0, wf);
    drv(0, pa, 1'b1, 1'b0);
    tick();
    drv(0, pb, 1'b1, 1'b0);
    while (b4.out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    for (int k = 0; k < 5; k++) begin
      if (b4.out_valid !== 1'b1 || b4.out_data !== ea || b4.in_ready !== 1'b0) bad++;
      tick();
    end
    total_cnt++;
    if (bad != 0 || b4.out_valid !== 1'b1 || b4.out_data !== ea)
      $display("FAIL bp_hold: got %0d bad cycles, data %h expected %h held", bad, b4.out_data, ea);
    else pass_cnt++;
    drv(0, pb, 1'b1, 1'b1);
    tick();
    drv(0, pb, 1'b1, 1'b0);
    total_cnt++;
    if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0)
      $display("FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", b4.in_ready, b4.out_valid);
    else pass_cnt++;
    tick();
    drv(0, pb, 1'b0, 1'b0);
    total_cnt++;
    if (b4.busy !== 1'b1 || b4.in_ready !== 1'b0)
      $display("FAIL bp_second_accept: got busy=%b ready=%b expected busy=1 ready=0", b4.busy, b4.in_ready);
    else pass_cnt++;
    lat = 0;
    while (b4.out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    total_cnt++;
    if (b4.out_data !== eb || lat != 10)
      $display("FAIL bp_second_ct: got %h after %0d edges expected %h after 10", b4.out_data, lat, eb);
    else pass_cnt++;
    drv(0, pb, 1'b0, 1'b1);
    tick();
    drv(0, pb, 1'b0, 1'b0);
  endtask

  task automatic test_reset_run();
    int seen = 0;
    set_w(0, m_expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4));
    drv(0, 128'h00112233445566778899aabbccddeeff, 1'b1, 1'b0);
    tick();
    drv(0, 128'h0, 1'b0, 1'b1);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    total_cnt++;
    if (b4.out_valid !== 1'b0 || b4.busy !== 1'b0 || b4.out_data !== 128'h0 || b4.in_ready !== 1'b0)
      $display("FAIL rst_run_outputs: got valid=%b busy=%b data=%h ready=%b expected 0/0/0/0",
               b4.out_valid, b4.busy, b4.out_data, b4.in_ready);
    else pass_cnt++;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (b4.out_valid !== 1'b0 || b4.busy !== 1'b0) seen++;
    end
    total_cnt++;
    if (seen != 0) $display("FAIL rst_run_no_output: got %0d active cycles expected 0", seen);
    else pass_cnt++;
    drv(0, 128'h0, 1'b0, 1'b0);
    run_block(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, "rst_run_c1");
  endtask

  task automatic test_back_to_back();
    logic [255:0]  key [3];
    logic [127:0]  pt [3];
    logic [127:0]  ect [3];
    int            acc [3];
    int            idx = 0;
    int            got = 0;
    int            n = 0;
    logic          accept_now, take;
    logic [127:0]  dout;
    for (int i = 0; i < 3; i++) begin
      key[i] = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      pt[i]  = {$urandom, $urandom, $urandom, $urandom};
      ect[i] = m_encrypt(pt[i], m_expand(key[i], 4), 10);
      acc[i] = 0;
    end
    set_w(0, m_expand(key[0], 4));
    drv(0, pt[0], 1'b1, 1'b1);
    while (got < 3 && n < 100) begin
      accept_now = b4.in_valid && b4.in_ready;
      take       = b4.out_valid && b4.out_ready;
      dout       = b4.out_data;
      tick();
      n++;
      if (take) begin
        total_cnt++;
        if (dout !== ect[got]) $display("FAIL stream_ct%0d: got %h expected %h", got, dout, ect[got]);
        else pass_cnt++;
        got++;
        if (got < 3) set_w(0, m_expand(key[got], 4));
      end
      if (accept_now) begin
        acc[idx] = cyc;
        idx++;
        if (idx < 3) drv(0, pt[idx], 1'b1, 1'b1);
        else         drv(0, 128'h0, 1'b0, 1'b1);
      end
    end
    total_cnt++;
    if (got != 3) $display("FAIL stream_count: got %0d blocks expected 3", got);
    else pass_cnt++;
    total_cnt++;
    if (acc[1] - acc[0] != 12 || acc[2] - acc[1] != 12)
      $display("FAIL stream_spacing: got %0d,%0d cycles expected 12,12", acc[1] - acc[0], acc[2] - acc[1]);
    else pass_cnt++;
    drv(0, 128'h0, 1'b0, 1'b0);
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_random();
    test_back_pressure();
    test_reset_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
